// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and result function for the pipelined logic unit.
// The function works at 64 bits; callers zero-extend operands and truncate.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_NOR    = 3'b010;
    localparam logic [2:0] OP_NAND   = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_XNOR   = 3'b101;
    localparam logic [2:0] OP_NOT_A  = 3'b110;
    localparam logic [2:0] OP_PASS_A = 3'b111;

    function automatic logic [63:0] lu_result(input logic [2:0]  op,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        logic [63:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NOR:   r = ~(a | b);
            OP_NAND:  r = ~(a & b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOT_A: r = ~a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline slice: valid, data and zero flag, loaded whenever the slice
// is empty or the downstream side can take its current contents.
module logic_unit_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             zero_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             load;

    assign load = ~valid_q | ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else if (load) begin
            valid_q <= valid_i;
            data_q  <= data_i;
            zero_q  <= zero_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control, aligned zero
// flag and a saturating count of completed output handshakes.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [CNT_W-1:0] op_cnt
);

    logic [63:0]      res_full;
    logic [WIDTH-1:0] res;
    logic [STAGES:0]  vch;
    logic [STAGES:0]  zch;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] dch [STAGES+1];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign res_full = lu_result(op, 64'(a), 64'(b));
    assign res      = res_full[WIDTH-1:0];

    assign vch[0] = in_valid;
    assign dch[0] = res;
    assign zch[0] = (res == '0);

    // Ready of slice g is the OR of out_ready and "some slice at or after g is
    // empty"; derived from registered valids so there is no combinational chain.
    assign rdy[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign rdy[g] = out_ready | ~(&vch[STAGES:g+1]);

        logic_unit_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (vch[g]),
            .data_i  (dch[g]),
            .zero_i  (zch[g]),
            .ready_i (rdy[g+1]),
            .valid_o (vch[g+1]),
            .data_o  (dch[g+1]),
            .zero_o  (zch[g+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vch[STAGES];
    assign y         = dch[STAGES];
    assign zero      = zch[STAGES];

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_cnt = cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It is the successor to the fixed 4-bit NOR gate. It takes two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake, and returns the registered result after STAGES cycles with full backpressure. It also provides a zero flag and a saturating count of completed operations. It sits between operand producers and any consumer that needs a registered, flow-controlled logic result.

Parameters:
WIDTH, 4, operand and result width in bits (1..64)
STAGES, 2, pipeline depth in register slices (1..4); sets latency
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low (one clock domain only)
in_valid  input  1  operands and opcode valid
in_ready  output  1  unit can accept operands this cycle
op  input  3  operation select, sampled with a and b
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
zero  output  1  high when y == 0; qualified by out_valid
op_cnt  output  CNT_W  number of output handshakes, saturating

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 NOR, 011 NAND
  - 100 XOR, 101 XNOR
  - 110 NOT a (b ignored), 111 pass a
- The result is computed combinationally from a, b and op at stage 0 input. It is registered into slice 0, then shifted through slices 1..STAGES-1.
- Each slice i holds v_i, data_i and zero_i.
  - ready_i = ~v_i | ready_{i+1}
  - ready_STAGES = out_ready
  - in_ready = ready_0
- Slice i loads when ready_i is high: v_i <= v_{i-1} (in_valid for slice 0).
- Output mapping: y, zero and out_valid come from the last slice.
- Latency: a beat accepted at edge N appears with out_valid high after edge N+STAGES-1. This assumes no stalls (STAGES=1: visible the cycle after acceptance).
- Throughput: one beat per cycle while out_ready is held high; no bubbles.
- Stall: while out_valid & ~out_ready, y and zero hold stable. Upstream slices keep filling until all are valid, then in_ready drops. No beat is lost or duplicated.
- zero is computed before the final register, so it is aligned with y.
- Simultaneous accept and emit when full: if out_ready is high, the pipeline shifts and in_ready stays high in the same cycle.
- op_cnt increments on each out_valid & out_ready cycle and saturates at all-ones. It does not wrap.
- Reset:
  - Asynchronous assertion clears all v_i, data_i and zero_i to 0, and op_cnt to 0. Output reset values: out_valid=0, y=0, zero=0, op_cnt=0.
  - in_ready reads 1 during and after reset, since all slices are empty.
  - Reset mid-stall discards in-flight beats with no output.
  - Deassertion is taken synchronously at the next clk edge.
- in_valid, a, b and op are don't-care when in_valid is low. An upstream beat that is not accepted must remain stable; the unit does not check this.

Decomposition:
- Package logic_unit_pkg: 3-bit opcode localparams (OP_AND .. OP_PASS_A) and a function computing the result from op, a and b, shared by the RTL and the bench reference model.
- Sub-module logic_unit_stage: one valid/data/zero slice with ready propagation, instantiated STAGES times via generate.
- The top level holds the opcode decode, the generate chain and op_cnt.

Test Plan:
All scenarios use WIDTH=4, STAGES=2.
- Reset then idle: out_valid=0, y=0, zero=0, op_cnt=0, in_ready=1.
- Back-to-back, out_ready=1:
  - NOR 0000/0000 -> 1111
  - NOR 1010/0101 -> 0000 with zero=1
  - XOR 1100/1100 -> 0000 with zero=1
  - AND 1011/0011 -> 0011
  - Expect out_valid 2 cycles after the first accept, one result per cycle in order, op_cnt=4.
- Backpressure: hold out_ready=0 after sending NAND 1111/1111 (->0000), OR 1001/1000 (->1001), XNOR 0010/0111 (->1010). Require in_ready=0 once 2 beats are held and y stable at 0000. Release out_ready: results emerge in order with no loss.
- Mid-stall reset: assert rst_n=0 asynchronously while full and stalled -> out_valid=0, y=0 and op_cnt=0 immediately, before the next clk edge. No stale beats after release.
- Counter saturation: CNT_W=4, send 20 PASS_A beats -> op_cnt stops at 1111.
- Random ops against the logic_unit_pkg model with random out_ready for STAGES=1 and 4, and WIDTH=1 and 32: every output matches in order.
